tt_um_hasekimi_and_monitor: RTL and testbench

TT_UM_HASEKIMI_AND_MONITOR -- requirements
Module: tt_um_hasekimi_and_monitor

---
 rtl/tt_um_hasekimi_and_monitor.sv | 117 +++++++++++
 tb/tb_tt_um_hasekimi_and_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_hasekimi_and_monitor.sv
// Monitor for an upstream AND stage: synchronizes r/clr/sel, filters r, and tracks edges, changes and sticky rises.
// Optional macro AND_MON_DEBOUNCE_EN builds the per-bit debounce filter; without it f follows the synchronized r directly.
module tt_um_hasekimi_and_monitor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [4:0] f;
  logic [4:0] f_d;
  logic [4:0] f_next;
  logic [4:0] rise;
  logic [4:0] sticky;
  logic [7:0] edge_cnt;
  logic [7:0] change_cnt;
  logic       chg;
  logic       clr;
  logic       sat;
  logic [1:0] sel;

  assign clr  = s2[5];
  assign sel  = s2[7:6];
  assign chg  = |(f ^ f_d);
  assign rise = f & ~f_d;
  assign sat  = (edge_cnt == 8'hFF);

  logic unused_uio;
  assign unused_uio = ^uio_in;

`ifdef AND_MON_DEBOUNCE_EN
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES);

  logic [4:0][3:0] db_cnt;
  logic [4:0][3:0] db_cnt_next;

  // A bit is accepted once it has disagreed with f for DB_LIMIT edges in a row.
  always_comb begin
    f_next      = f;
    db_cnt_next = '0;
    for (int i = 0; i < 5; i++) begin
      if (s2[i] != f[i]) begin
        if (db_cnt[i] + 4'd1 == DB_LIMIT) begin
          f_next[i] = s2[i];
        end else begin
          db_cnt_next[i] = db_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else if (ena) begin
      db_cnt <= db_cnt_next;
    end
  end
`else
  logic unused_db_cycles;
  assign unused_db_cycles = ^DEBOUNCE_CYCLES;
  assign f_next = s2[4:0];
`endif

  // Clear wins over any increment or sticky set on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      f          <= '0;
      f_d        <= '0;
      edge_cnt   <= '0;
      change_cnt <= '0;
      sticky     <= '0;
    end else if (ena) begin
      s1  <= ui_in;
      s2  <= s1;
      f   <= f_next;
      f_d <= f;
      if (clr) begin
        edge_cnt   <= '0;
        change_cnt <= '0;
        sticky     <= '0;
      end else begin
        if (rise[4] && !sat) begin
          edge_cnt <= edge_cnt + 8'd1;
        end
        if (chg) begin
          change_cnt <= change_cnt + 8'd1;
        end
        sticky <= sticky | rise;
      end
    end
  end

  always_comb begin
    uo_out = '0;
    case (sel)
      2'b00:   uo_out = {3'b000, f};
      2'b01:   uo_out = edge_cnt;
      2'b10:   uo_out = change_cnt;
      default: uo_out = {3'b000, sticky};
    endcase
  end

  assign uio_out = {6'b000000, chg, sat};
  assign uio_oe  = 8'h03;

endmodule

// File: tb/tb_tt_um_hasekimi_and_monitor.sv
// Bench for tt_um_hasekimi_and_monitor: directed vectors, a history-window behavioural model checked every cycle.
module tb_tt_um_hasekimi_and_monitor;

  localparam int D = 4;
`ifdef AND_MON_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  // Posedges from an input change until f shows it.
  localparam int LAT = DB_EN ? D + 2 : 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_hasekimi_and_monitor #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: f bit flips once the last D synchronized samples all disagree with it.
  logic [7:0] m_s1, m_s2;
  logic [4:0] m_f, m_fd, m_sticky;
  int         m_edge, m_chgc;
  logic [4:0] hist[$];
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [4:0] nf;
    logic [4:0] m_rise;
    bit         ok;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_f = '0; m_fd = '0; m_sticky = '0;
      m_edge = 0; m_chgc = 0;
      hist.delete();
      m_valid = 1'b1;
    end else if (ena) begin
      hist.push_front(m_s2[4:0]);
      if (hist.size() > 16) void'(hist.pop_back());
      nf = m_s2[4:0];
      if (DB_EN) begin
        nf = m_f;
        for (int i = 0; i < 5; i++) begin
          ok = (hist.size() >= D);
          for (int j = 0; j < D; j++) begin
            if (ok && hist[j][i] == m_f[i]) ok = 1'b0;
          end
          if (ok) nf[i] = m_s2[i];
        end
      end
      m_rise = m_f & ~m_fd;
      if (m_s2[5]) begin
        m_edge = 0; m_chgc = 0; m_sticky = '0;
      end else begin
        if (m_rise[4] && m_edge < 255) m_edge = m_edge + 1;
        if (m_f != m_fd) m_chgc = (m_chgc + 1) % 256;
        m_sticky = m_sticky | m_rise;
      end
      m_fd = m_f;
      m_f  = nf;
      m_s2 = m_s1;
      m_s1 = ui_in;
    end
  end

  function automatic logic [7:0] exp_uo();
    case (m_s2[7:6])
      2'b00:   return {3'b000, m_f};
      2'b01:   return m_edge[7:0];
      2'b10:   return m_chgc[7:0];
      default: return {3'b000, m_sticky};
    endcase
  endfunction

  always @(negedge clk) begin : compare
    if (m_valid) begin
      check8("model_uo_out", uo_out, exp_uo());
      check8("model_uio_out", uio_out, {6'b000000, (m_f != m_fd), (m_edge == 255)});
      check8("uio_oe", uio_oe, 8'h03);
    end
  end

  always @(negedge clk) uio_in = 8'($urandom_range(0, 255));

  // All driver tasks start and end at a negedge.
  task automatic hold(input logic [7:0] v, input int n);
    ui_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic en);
    ui_in = 8'h00;
    rst_n = 1'b0;
    ena   = en;
    repeat (n) @(negedge clk);
    check8("rst_uo_out", uo_out, 8'h00);
    check8("rst_uio_out", uio_out, 8'h00);
    check8("rst_uio_oe", uio_oe, 8'h03);
    rst_n = 1'b1;
    ena   = 1'b1;
  endtask

  task automatic measure(input logic [7:0] v, input logic [7:0] want, input string name);
    int n;
    n = 0;
    ui_in = v;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (uo_out == want) begin
        n = c;
        break;
      end
    end
    checkint(name, n, LAT);
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] seen;
    logic       chg_seen;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(negedge clk);

    // All r bits high: latency and a single chg pulse.
    do_reset(2, 1'b1);
    measure(8'h1F, 8'h1F, "t1_latency");
    check8("t1_chg_pulse", uio_out, 8'h02);
    @(negedge clk);
    check8("t1_chg_end", uio_out, 8'h00);
    check8("t1_hold", uo_out, 8'h1F);

    // Short glitch on r[4].
    do_reset(2, 1'b1);
    hold(8'h10, 3);
    ui_in    = 8'h00;
    seen     = 8'h00;
    chg_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen     = seen | uo_out;
      chg_seen = chg_seen | uio_out[1];
    end
    check8("t2_f_glitch", seen, DB_EN ? 8'h00 : 8'h10);
    check8("t2_chg_glitch", {7'b0, chg_seen}, DB_EN ? 8'h00 : 8'h01);
    hold(8'h40, 4);
    check8("t2_edge_cnt", uo_out, DB_EN ? 8'h00 : 8'h01);

    // 300 rising edges on r[4]: saturation, then clear.
    do_reset(2, 1'b1);
    hold(8'h40, 2);
    for (int i = 0; i < 300; i++) begin
      hold(8'h50, D + 3);
      hold(8'h40, D + 3);
      if (i == 253) check8("t3_cnt_254", uo_out, 8'hFE);
      if (i == 253) check8("t3_sat_254", {7'b0, uio_out[0]}, 8'h00);
      if (i == 254) check8("t3_cnt_255", uo_out, 8'hFF);
    end
    check8("t3_saturated", uo_out, 8'hFF);
    check8("t3_sat_flag", {7'b0, uio_out[0]}, 8'h01);
    hold(8'h60, 1);
    hold(8'h40, 1);
    check8("t3_before_clr", uo_out, 8'hFF);
    @(negedge clk);
    check8("t3_cleared", uo_out, 8'h00);
    check8("t3_sat_cleared", {7'b0, uio_out[0]}, 8'h00);

    // change_cnt wrap via toggles on r[0].
    do_reset(2, 1'b1);
    hold(8'h80, 2);
    for (int i = 0; i < 259; i++) begin
      if (i == 255) check8("t4_cnt_255", uo_out, 8'hFF);
      if (i == 256) check8("t4_wrap", uo_out, 8'h00);
      hold(8'h80 | 8'((i + 1) % 2), D + 3);
    end
    check8("t4_after_wrap", uo_out, 8'h03);

    // Sticky set, clear, and clear winning over a simultaneous rise.
    do_reset(2, 1'b1);
    hold(8'hC5, D + 3);
    hold(8'hC0, D + 3);
    check8("t5_sticky", uo_out, 8'h05);
    hold(8'hE0, 1);
    hold(8'hC0, 4);
    check8("t5_sticky_clr", uo_out, 8'h00);
    hold(8'hE4, D + 6);
    hold(8'hC4, 6);
    check8("t5_clr_wins", uo_out, 8'h00);
    hold(8'hC0, D + 3);
    hold(8'hC4, D + 3);
    check8("t5_sticky_r2", uo_out, 8'h04);

    // ena freeze, reset with ena low, and reset mid-debounce.
    do_reset(2, 1'b0);
    measure(8'h0A, 8'h0A, "t6_latency");
    hold(8'h0A, 2);
    check8("t6_settled", uo_out, 8'h0A);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hold(8'h15, 1);
      check8("t6_frozen_uo", uo_out, 8'h0A);
      check8("t6_frozen_uio", uio_out, 8'h00);
    end
    ena = 1'b1;
    hold(8'h15, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check8("t6_rst_uo", uo_out, 8'h00);
    check8("t6_rst_uio", uio_out, 8'h00);
    check8("t6_rst_oe", uio_oe, 8'h03);
    rst_n = 1'b1;
    measure(8'h15, 8'h15, "t6_post_reset_latency");
    hold(8'h15, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
